// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised UART receiver with configurable data width,
//            optional parity, 1 or 2 stop bits and a run-time baud divisor.
//            Rejects false starts; rdy is sticky and an overrun is flagged
//            when a frame completes before the previous one was consumed.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            rx         - serial input, idle high, asynchronous to clk
//            baud       - clk cycles per bit, captured at start-bit detect
//            clr_rdy    - consumer ack, clears rdy and overrun
//            rx_data    - last received data word
//            rdy        - frame available (sticky)
//            parity_err - parity mismatch on last frame
//            frame_err  - a checked stop bit was sampled low on last frame
//            overrun    - frame completed while rdy was still set (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int BAUD_W      = 13,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [BAUD_W-1:0]    baud,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int                 c_bcnt_w    = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0]  c_one       = {{(BAUD_W-1){1'b0}}, 1'b1};
    localparam logic [c_bcnt_w-1:0] c_bit_one  = {{(c_bcnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_bcnt_w-1:0] c_last_data = c_bcnt_w'(DATA_BITS - 1);
    localparam logic [c_bcnt_w-1:0] c_last_stop = c_bcnt_w'(STOP_BITS - 1);
    localparam logic               c_odd       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;
    logic [BAUD_W-1:0]      r_baud;
    logic [BAUD_W-1:0]      r_cnt;
    logic [c_bcnt_w-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   w_strobe;
    logic                   w_load_half;
    logic                   w_complete;

    // Synchroniser plus one edge-detect flop; all preset to the idle level
    // so that leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_half = 1'b0;
        w_complete  = 1'b0;
        w_strobe    = (r_state != S_IDLE) && (r_cnt == '0);
        case (r_state)
            S_IDLE: begin
                if (r_prev && !w_sync) begin
                    w_state_nxt = S_START;
                    w_load_half = 1'b1;
                end
            end
            S_START: begin
                // Line back high at mid start bit: glitch, drop it silently.
                if (w_strobe) begin
                    w_state_nxt = w_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_strobe && (r_bit_cnt == c_last_data)) begin
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_strobe) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Return to idle mid stop bit so a start edge directly
                // following the stop bit is still caught.
                if (w_strobe && (r_bit_cnt == c_last_stop)) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit-period counter. The first load is half a bit so every later
    // strobe lands in the middle of a bit; the divisor is frozen per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud <= '0;
            r_cnt  <= '0;
        end else if (w_load_half) begin
            r_baud <= baud;
            r_cnt  <= (baud >> 1) - c_one;
        end else if (w_strobe) begin
            r_cnt <= r_baud - c_one;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Sample counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_bit_cnt <= '0;
        end else if (w_strobe) begin
            r_bit_cnt <= r_bit_cnt + c_bit_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_load_half) begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_strobe) begin
                case (r_state)
                    S_DATA:   r_shift <= {w_sync, r_shift[DATA_BITS-1:1]};
                    S_PARITY: r_perr  <= (^r_shift) ^ w_sync ^ c_odd;
                    S_STOP:   r_ferr  <= r_ferr | ~w_sync;
                    default:  ;
                endcase
            end
        end
    end

    // Completion takes priority over the consumer ack, so a frame that
    // lands in the same cycle as clr_rdy is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_complete) begin
            rx_data    <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr | ~w_sync;
            rdy        <= 1'b1;
            overrun    <= ~clr_rdy & (overrun | rdy);
        end else if (clr_rdy) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Self-checking bench for uart_rx_cfg. Two receivers are built:
//            u_dut_a as 8N1 and u_dut_b as 8E2 with a deeper synchroniser.
//            Frames are generated as bit lists and the expected results are
//            derived from the frame contents and the consumer handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int BAUD_W = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              rx_a, rx_b, clr_a, clr_b;
    logic [BAUD_W-1:0] baud_a, baud_b;
    logic [7:0]        data_a, data_b;
    logic              rdy_a, pe_a, fe_a, ov_a;
    logic              rdy_b, pe_b, fe_b, ov_b;

    uart_rx_cfg #(
        .DATA_BITS(8), .BAUD_W(BAUD_W), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .SYNC_STAGES(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .baud(baud_a), .clr_rdy(clr_a),
        .rx_data(data_a), .rdy(rdy_a), .parity_err(pe_a), .frame_err(fe_a),
        .overrun(ov_a)
    );

    uart_rx_cfg #(
        .DATA_BITS(8), .BAUD_W(BAUD_W), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(2), .SYNC_STAGES(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .baud(baud_b), .clr_rdy(clr_b),
        .rx_data(data_b), .rdy(rdy_b), .parity_err(pe_b), .frame_err(fe_b),
        .overrun(ov_b)
    );

    int   sel = 0;
    logic [7:0] obs_data;
    logic       obs_rdy, obs_pe, obs_fe, obs_ov;
    assign obs_data = (sel == 1) ? data_b : data_a;
    assign obs_rdy  = (sel == 1) ? rdy_b  : rdy_a;
    assign obs_pe   = (sel == 1) ? pe_b   : pe_a;
    assign obs_fe   = (sel == 1) ? fe_b   : fe_a;
    assign obs_ov   = (sel == 1) ? ov_b   : ov_a;

    // Reference state per receiver
    logic [7:0] exp_data [2];
    bit         exp_rdy  [2];
    bit         exp_pe   [2];
    bit         exp_fe   [2];
    bit         exp_ovr  [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (u%0d): got 0x%0h expected 0x%0h at %0t", tag, sel, obs, exp, $time);
        end
    endtask

    function automatic int n_stop_cur();
        return (sel == 1) ? 2 : 1;
    endfunction

    function automatic bit par_en_cur();
        return (sel == 1);
    endfunction

    function automatic int n_sync_cur();
        return (sel == 1) ? 3 : 2;
    endfunction

    task automatic drive_rx(input logic v);
        if (sel == 1) rx_b = v; else rx_a = v;
    endtask

    task automatic drive_clr(input logic v);
        if (sel == 1) clr_b = v; else clr_a = v;
    endtask

    task automatic drive_baud(input int b);
        if (sel == 1) baud_b = BAUD_W'(b); else baud_a = BAUD_W'(b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_data[i] = 8'h00;
            exp_rdy[i]  = 1'b0;
            exp_pe[i]   = 1'b0;
            exp_fe[i]   = 1'b0;
            exp_ovr[i]  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_val("rx_data",    {24'd0, obs_data}, {24'd0, exp_data[sel]});
        check_val("rdy",        {31'd0, obs_rdy},  {31'd0, exp_rdy[sel]});
        check_val("parity_err", {31'd0, obs_pe},   {31'd0, exp_pe[sel]});
        check_val("frame_err",  {31'd0, obs_fe},   {31'd0, exp_fe[sel]});
        check_val("overrun",    {31'd0, obs_ov},   {31'd0, exp_ovr[sel]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_rx(1'b1);
        end
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1;
        drive_clr(1'b1);
        @(posedge clk); #1;
        drive_clr(1'b0);
        @(negedge clk);
        exp_rdy[sel] = 1'b0;
        exp_ovr[sel] = 1'b0;
    endtask

    // Drives one whole frame on the selected line. Returns the cycle index
    // at which rdy was seen rising (after having been seen low), or -1.
    // rst_at >= 0 pulses reset at that cycle and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input int b, input bit bad_par,
                              input bit [1:0] bad_stop, input bit hold_clr,
                              input int rst_at, output int rise);
        bit q[$];
        int j;
        bit seen0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_en_cur()) q.push_back((^d) ^ bad_par);
        for (int s = 0; s < n_stop_cur(); s++) q.push_back(~bad_stop[s]);
        drive_baud(b);
        drive_clr(hold_clr);
        rise  = -1;
        seen0 = 1'b0;
        j     = 0;
        foreach (q[k]) begin
            repeat (b) begin
                @(posedge clk); #1;
                drive_rx(q[k]);
                if (j == rst_at) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    drive_rx(1'b1);
                    drive_clr(1'b0);
                    @(negedge clk);
                    return;
                end
                // Divisor changes after capture must not disturb the frame.
                if (j == 6) drive_baud($urandom_range(16, 255));
                @(negedge clk);
                if (!obs_rdy) begin
                    seen0 = 1'b1;
                end else if (seen0 && rise < 0) begin
                    rise = j;
                    if (hold_clr) drive_clr(1'b0);
                end
                j++;
            end
        end
        drive_clr(1'b0);
    endtask

    task automatic frame_and_check(input logic [7:0] d, input int b, input bit bad_par,
                                   input bit [1:0] bad_stop, input bit hold_clr);
        int  rise;
        int  exp_lat;
        int  nbits;
        bit  prev_rdy;
        send_frame(d, b, bad_par, bad_stop, hold_clr, -1, rise);
        prev_rdy        = exp_rdy[sel];
        exp_data[sel]   = d;
        exp_pe[sel]     = par_en_cur() & bad_par;
        exp_fe[sel]     = bad_stop[0] | ((n_stop_cur() == 2) & bad_stop[1]);
        if (hold_clr)      exp_ovr[sel] = 1'b0;
        else if (prev_rdy) exp_ovr[sel] = 1'b1;
        exp_rdy[sel]    = 1'b1;
        if (hold_clr || !prev_rdy) begin
            // Line fall to mid last stop bit, plus synchroniser and edge
            // detect, plus the output register.
            nbits   = 1 + 8 + (par_en_cur() ? 1 : 0) + n_stop_cur();
            exp_lat = n_sync_cur() + 1 + b / 2 + (nbits - 1) * b + 1;
            check_val("rdy_latency",
                      (rise >= exp_lat - 3 && rise <= exp_lat + 3) ? exp_lat : rise,
                      exp_lat);
        end
        check_outputs();
    endtask

    task automatic false_start(input int b);
        drive_baud(b);
        repeat (4) begin
            @(posedge clk); #1;
            drive_rx(1'b0);
        end
        idle(3 * b);
        check_outputs();
    endtask

    task automatic random_frames(input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] d;
            int         b;
            int         gap;
            bit         bp;
            bit [1:0]   bs;
            bit         hc;
            d  = 8'($urandom);
            b  = $urandom_range(16, 32);
            bp = par_en_cur() && ($urandom_range(0, 3) == 0);
            bs = 2'b00;
            if ($urandom_range(0, 3) == 0) bs[$urandom_range(0, n_stop_cur() - 1)] = 1'b1;
            hc = ($urandom_range(0, 5) == 0);
            if (!hc && $urandom_range(0, 2) == 0) clr_pulse();
            frame_and_check(d, b, bp, bs, hc);
            if (bs != 2'b00)                gap = 4 + $urandom_range(0, 4);
            else if ($urandom_range(0, 1)) gap = 0;
            else                            gap = $urandom_range(1, 10);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        rst_n  = 1'b0;
        rx_a   = 1'b1;
        rx_b   = 1'b1;
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        baud_a = BAUD_W'(16);
        baud_b = BAUD_W'(16);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        sel = 0; #1; check_outputs();
        sel = 1; #1; check_outputs();

        // 8N1 receiver
        sel = 0; #1;
        idle(4);
        frame_and_check(8'hA5, 16, 1'b0, 2'b00, 1'b0);
        clr_pulse();
        check_outputs();
        false_start(16);
        frame_and_check(8'h3C, 16, 1'b0, 2'b00, 1'b0);
        clr_pulse();
        frame_and_check(8'h11, 16, 1'b0, 2'b00, 1'b0);
        frame_and_check(8'h22, 16, 1'b0, 2'b00, 1'b0);
        clr_pulse();
        check_outputs();
        frame_and_check(8'h81, 20, 1'b0, 2'b00, 1'b0);
        frame_and_check(8'h5A, 17, 1'b0, 2'b00, 1'b1);
        frame_and_check(8'hF0, 16, 1'b0, 2'b01, 1'b0);
        idle(6);
        random_frames(25);
        idle(8);

        // 8E2 receiver
        sel = 1; #1;
        idle(4);
        frame_and_check(8'h3C, 16, 1'b1, 2'b00, 1'b0);
        clr_pulse();
        frame_and_check(8'h55, 16, 1'b0, 2'b10, 1'b0);
        idle(6);
        frame_and_check(8'h96, 24, 1'b0, 2'b00, 1'b0);
        false_start(18);
        random_frames(25);
        idle(8);

        // Reset in the middle of the data bits
        sel = 0; #1;
        send_frame(8'hC3, 16, 1'b0, 2'b00, 1'b0, 3 * 16, rise);
        model_reset();
        idle(4);
        sel = 0; #1; check_outputs();
        sel = 1; #1; check_outputs();
        sel = 0; #1;
        frame_and_check(8'h7E, 16, 1'b0, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
